// File: rtl/bram_pkg.sv
// Shared types and default geometry for the banked BRAM block and its writer/reader.
package bram_pkg;
  localparam int BRAM_ADDR_WIDTH_DEF = 10;
  localparam int BANK_DATA_WIDTH_DEF = 8;
  localparam int BANK_CNT_DEF        = 4;

  typedef enum logic [2:0] {IDLE, RD, LATCH, EMIT, FIN} rd_state_e;
endpackage

// File: rtl/bram_block.sv
// Banked BRAM: one byte lane per bank, one-hot bank write enables, registered read.
module bram_block import bram_pkg::*; #(
  parameter int BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF,
  parameter int BANK_DATA_WIDTH = BANK_DATA_WIDTH_DEF,
  parameter int BANK_CNT        = BANK_CNT_DEF
)(
  input  logic                                clock,
  input  logic [BANK_CNT-1:0]                 we,
  input  logic [BRAM_ADDR_WIDTH-1:0]          wr_addr,
  input  logic [BANK_DATA_WIDTH-1:0]          din,
  input  logic [BRAM_ADDR_WIDTH-1:0]          rd_addr,
  output logic [BANK_CNT*BANK_DATA_WIDTH-1:0] dout
);
  for (genvar g = 0; g < BANK_CNT; g++) begin : g_bank
    logic [BANK_DATA_WIDTH-1:0] mem [2**BRAM_ADDR_WIDTH];
    logic [BANK_DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clock) begin
      if (we[g]) mem[wr_addr] <= din;
      rd_q <= mem[rd_addr];
    end

    assign dout[g*BANK_DATA_WIDTH +: BANK_DATA_WIDTH] = rd_q;
  end
endmodule

// File: rtl/lane_serializer.sv
// Word buffer plus lane counter driving a byte-wide valid/ready output register.
module lane_serializer #(
  parameter int BANK_DATA_WIDTH = 8,
  parameter int BANK_CNT        = 4,
  parameter int LANE_IDX_WIDTH  = 2
)(
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                load,
  input  logic                                last_word,
  input  logic [BANK_CNT*BANK_DATA_WIDTH-1:0] word_in,
  input  logic                                out_ready,
  output logic [BANK_DATA_WIDTH-1:0]          out_data,
  output logic                                out_valid,
  output logic                                out_last,
  output logic                                word_end
);
  logic [BANK_CNT-1:0][BANK_DATA_WIDTH-1:0] wbuf_q;
  logic [LANE_IDX_WIDTH-1:0]                lane_q, lane_nxt;
  logic [BANK_DATA_WIDTH-1:0]               data_q;
  logic                                     valid_q, last_q, fire, at_end;

  assign fire     = valid_q & out_ready;
  assign at_end   = (lane_q == LANE_IDX_WIDTH'(BANK_CNT-1));
  assign lane_nxt = lane_q + 1'b1;
  assign word_end = fire & at_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbuf_q  <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      wbuf_q  <= word_in;
      lane_q  <= '0;
      data_q  <= word_in[BANK_DATA_WIDTH-1:0];
      valid_q <= 1'b1;
      last_q  <= last_word && (BANK_CNT == 1);
    end else if (fire) begin
      // data is left in place when the word drains; only valid drops
      if (at_end) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        lane_q <= lane_nxt;
        data_q <= wbuf_q[lane_nxt];
        last_q <= last_word && (lane_nxt == LANE_IDX_WIDTH'(BANK_CNT-1));
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
endmodule

// File: rtl/bram_block_reader.sv
// Reads a run of wide BRAM words and streams them out one bank lane per beat.
module bram_block_reader import bram_pkg::*; #(
  parameter int BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF,
  parameter int BANK_DATA_WIDTH = BANK_DATA_WIDTH_DEF,
  parameter int BANK_CNT        = BANK_CNT_DEF,
  parameter int LANE_IDX_WIDTH  = (BANK_CNT > 1) ? $clog2(BANK_CNT) : 1
)(
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [BRAM_ADDR_WIDTH-1:0]          base_addr,
  input  logic [BRAM_ADDR_WIDTH:0]            word_cnt,
  output logic                                busy,
  output logic                                done,
  output logic [BRAM_ADDR_WIDTH-1:0]          rd_addr,
  input  logic [BANK_CNT*BANK_DATA_WIDTH-1:0] rd_data,
  output logic [BANK_DATA_WIDTH-1:0]          out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last
);
  rd_state_e                  state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [BRAM_ADDR_WIDTH:0]   remain_q, remain_d;
  logic                       load, last_word, word_end;

  assign last_word = (remain_q == (BRAM_ADDR_WIDTH+1)'(1));

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    remain_d  = remain_q;
    load      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (word_cnt != '0) begin
          rd_addr_d = base_addr;
          remain_d  = word_cnt;
          state_d   = RD;
        end else begin
          state_d = FIN;
        end
      end
      RD:    state_d = LATCH;
      LATCH: begin
        load    = 1'b1;
        state_d = EMIT;
      end
      EMIT: if (word_end) begin
        if (last_word) begin
          state_d = FIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
          remain_d  = remain_q - 1'b1;
          state_d   = RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      remain_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      remain_q  <= remain_d;
    end
  end

  lane_serializer #(
    .BANK_DATA_WIDTH(BANK_DATA_WIDTH),
    .BANK_CNT       (BANK_CNT),
    .LANE_IDX_WIDTH (LANE_IDX_WIDTH)
  ) u_ser (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .last_word(last_word),
    .word_in  (rd_data),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .word_end (word_end)
  );

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);
  assign rd_addr = rd_addr_q;
endmodule

// File: tb/tb_bram_block_reader.sv
// Directed bench: reader draining a real banked BRAM preloaded through its write port.
module tb_bram_block_reader;
  import bram_pkg::*;
  localparam int AW = BRAM_ADDR_WIDTH_DEF;
  localparam int W  = BANK_DATA_WIDTH_DEF;
  localparam int N  = BANK_CNT_DEF;

  logic          clock = 1'b0;
  logic          reset, start, out_ready;
  logic [AW-1:0] base_addr, rd_addr, wr_addr;
  logic [AW:0]   word_cnt;
  logic          busy, done, out_valid, out_last;
  logic [W-1:0]  out_data, din;
  logic [N-1:0]  we;
  logic [N*W-1:0] rd_data;

  always #5 clock = ~clock;

  bram_block_reader dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  bram_block mem (
    .clock(clock), .we(we), .wr_addr(wr_addr), .din(din),
    .rd_addr(rd_addr), .dout(rd_data)
  );

  int nvec = 0, nerr = 0;
  logic [W-1:0]  beats [64];
  logic          lasts [64];
  logic [AW-1:0] addrs [64];
  int nb, done_cyc, done_cnt, last_cnt;
  logic busy0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [N*W-1:0] w);
    for (int i = 0; i < N; i++) begin
      @(negedge clock);
      we = N'(1) << i;
      wr_addr = a;
      din = w[i*W +: W];
    end
    @(negedge clock);
    we = '0;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] c);
    @(negedge clock);
    base_addr = b;
    word_cnt  = c;
    start     = 1'b1;
  endtask

  // cyc 0 is the cycle right after the start-sampling edge
  task automatic run_stream(input bit toggle, input int pulse_cyc, input int abort_cyc, input int budget);
    logic held_v, hl;
    logic [W-1:0] hd;
    held_v = 1'b0; hl = 1'b0; hd = '0;
    nb = 0; done_cyc = -1; done_cnt = 0; last_cnt = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clock);
      start = (cyc == pulse_cyc);
      if (cyc == 0) busy0 = busy;
      if (cyc == abort_cyc) begin
        reset = 1'b1;
        #1;
        return;
      end
      if (held_v) begin
        chk("stall_valid", 32'(out_valid), 32'(1));
        chk("stall_data", 32'(out_data), 32'(hd));
        chk("stall_last", 32'(out_last), 32'(hl));
      end
      out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (nb < 64) begin
          beats[nb] = out_data;
          lasts[nb] = out_last;
          addrs[nb] = rd_addr;
        end
        if (out_last) last_cnt++;
        nb++;
      end
      held_v = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] prev_addr;
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0; word_cnt = '0;
    we = '0; wr_addr = '0; din = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd_addr", 32'(rd_addr), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_last", 32'(out_last), 32'(0));
    reset = 1'b0;

    // single word, lane order and last flag
    wr_word(10'd5, 32'h44332211);
    launch(10'd5, 11'd1);
    run_stream(1'b0, -1, -1, 40);
    chk("t1_busy0", 32'(busy0), 32'(1));
    chk("t1_nbeats", 32'(nb), 32'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t1_beat", 32'(beats[i]), 32'((i + 1) * 17));
      chk("t1_last", 32'(lasts[i]), 32'(i == 3));
    end
    chk("t1_addr", 32'(addrs[0]), 32'(5));
    chk("t1_done_cyc", 32'(done_cyc), 32'(6));
    chk("t1_done_cnt", 32'(done_cnt), 32'(1));
    chk("t1_busy_end", 32'(busy), 32'(0));

    // four words, full throughput
    for (int a = 0; a < 4; a++)
      wr_word(AW'(a), {8'(4*a+3), 8'(4*a+2), 8'(4*a+1), 8'(4*a)});
    launch(10'd0, 11'd4);
    run_stream(1'b0, -1, -1, 80);
    chk("t2_nbeats", 32'(nb), 32'(16));
    for (int i = 0; i < 16; i++) begin
      chk("t2_beat", 32'(beats[i]), 32'(i));
      chk("t2_addr", 32'(addrs[i]), 32'(i / 4));
    end
    chk("t2_last_cnt", 32'(last_cnt), 32'(1));
    chk("t2_last15", 32'(lasts[15]), 32'(1));
    chk("t2_done_cyc", 32'(done_cyc), 32'(24));

    // same run with back-pressure pattern 1,0,0
    launch(10'd0, 11'd4);
    run_stream(1'b1, -1, -1, 200);
    chk("t3_nbeats", 32'(nb), 32'(16));
    for (int i = 0; i < 16; i++) chk("t3_beat", 32'(beats[i]), 32'(i));
    chk("t3_last_cnt", 32'(last_cnt), 32'(1));
    chk("t3_done_cnt", 32'(done_cnt), 32'(1));

    // address wrap from the top word to word 0
    wr_word(10'd1023, 32'hD3C2B1A0);
    launch(10'd1023, 11'd2);
    run_stream(1'b0, -1, -1, 60);
    chk("t4_nbeats", 32'(nb), 32'(8));
    chk("t4_b0", 32'(beats[0]), 32'h0A0);
    chk("t4_b3", 32'(beats[3]), 32'h0D3);
    chk("t4_b4", 32'(beats[4]), 32'h000);
    chk("t4_b7", 32'(beats[7]), 32'h003);
    chk("t4_addr_hi", 32'(addrs[3]), 32'(1023));
    chk("t4_addr_lo", 32'(addrs[4]), 32'(0));
    chk("t4_last7", 32'(lasts[7]), 32'(1));
    chk("t4_done_cnt", 32'(done_cnt), 32'(1));
    chk("t4_done_cyc", 32'(done_cyc), 32'(12));

    // zero-length run
    prev_addr = rd_addr;
    launch(10'd77, 11'd0);
    run_stream(1'b0, -1, -1, 10);
    chk("t5_done_cyc", 32'(done_cyc), 32'(0));
    chk("t5_nbeats", 32'(nb), 32'(0));
    chk("t5_rd_addr", 32'(rd_addr), 32'(prev_addr));

    // start pulsed mid-run and coincident with done: both ignored
    launch(10'd5, 11'd1);
    run_stream(1'b0, 3, -1, 40);
    chk("t6_nbeats", 32'(nb), 32'(4));
    chk("t6_done_cnt", 32'(done_cnt), 32'(1));
    launch(10'd5, 11'd1);
    run_stream(1'b0, 6, -1, 40);
    chk("t6b_nbeats", 32'(nb), 32'(4));
    chk("t6b_done_cnt", 32'(done_cnt), 32'(1));
    chk("t6b_busy_end", 32'(busy), 32'(0));

    // reset during the second word of a three-word run
    launch(10'd0, 11'd3);
    run_stream(1'b0, -1, 9, 40);
    chk("t7_partial", 32'(nb), 32'(5));
    chk("t7_valid", 32'(out_valid), 32'(0));
    chk("t7_busy", 32'(busy), 32'(0));
    chk("t7_done", 32'(done), 32'(0));
    chk("t7_rd_addr", 32'(rd_addr), 32'(0));
    chk("t7_last", 32'(out_last), 32'(0));
    chk("t7_data", 32'(out_data), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    launch(10'd5, 11'd1);
    run_stream(1'b0, -1, -1, 40);
    chk("t7_re_nbeats", 32'(nb), 32'(4));
    chk("t7_re_b0", 32'(beats[0]), 32'h11);
    chk("t7_re_b3", 32'(beats[3]), 32'h44);
    chk("t7_re_done_cyc", 32'(done_cyc), 32'(6));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
